// File: rtl/i_term_accum.sv
// rtl/i_term_accum.sv - PID integral-term accumulator with settle window, decimation, leak and overflow handling
module i_term_accum #(
  parameter int ERR_W   = 11,
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 10,
  parameter int SHIFT   = 6,
  parameter int DECIM   = 1,
  parameter int SETTLE  = 2,
  parameter int LEAK_SH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ERR_W-1:0] err_sat,
  input  logic             err_vld,
  input  logic             go,
  input  logic             moving,
  input  logic             line_present,
  input  logic             sat_mode,
  input  logic             freeze,
  output logic [OUT_W-1:0] I_term,
  output logic             sat_flag,
  output logic             integ_active
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETTLE = 2'd1, ST_INTEG = 2'd2} state_t;

  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               set_cnt_q, set_cnt_d;
  logic [7:0]               dec_cnt_q, dec_cnt_d;
  logic                     sat_q, sat_d;
  logic                     line_q, line_d;

  logic                     line_edge;
  logic                     clear;
  logic signed [ACC_W-1:0]  acc_l;
  logic signed [ACC_W:0]    sum;
  logic                     ovf;
  logic signed [ACC_W-1:0]  clamp_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      set_cnt_q <= '0;
      dec_cnt_q <= '0;
      sat_q     <= 1'b0;
      line_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      set_cnt_q <= set_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      sat_q     <= sat_d;
      line_q    <= line_d;
    end
  end

  assign line_d    = line_present;
  assign line_edge = line_present & ~line_q;
  assign clear     = ~go | ~moving | line_edge;

  always_comb begin
    state_d = state_q;
    if (!go || !moving) begin
      state_d = ST_IDLE;
    end else if (line_edge) begin
      state_d = ST_SETTLE;
    end else if (!freeze) begin
      case (state_q)
        ST_IDLE:   state_d = (SETTLE == 0) ? ST_INTEG : ST_SETTLE;
        ST_SETTLE: begin
          // An empty settle window (entered via line edge) passes straight through.
          if (SETTLE == 0 || (err_vld && set_cnt_q == SET_LAST)) state_d = ST_INTEG;
        end
        ST_INTEG:  state_d = ST_INTEG;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Leak is applied only on accumulate cycles, before the add.
  always_comb begin
    acc_l     = (LEAK_SH == 0) ? acc_q : acc_q - (acc_q >>> LEAK_SH);
    sum       = {{(ACC_W + 1 - ERR_W){err_sat[ERR_W-1]}}, err_sat} + {acc_l[ACC_W-1], acc_l};
    ovf       = sum[ACC_W] ^ sum[ACC_W-1];
    clamp_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_comb begin
    acc_d     = acc_q;
    set_cnt_d = set_cnt_q;
    dec_cnt_d = dec_cnt_q;
    sat_d     = sat_q;
    if (clear) begin
      acc_d     = '0;
      set_cnt_d = '0;
      dec_cnt_d = '0;
      sat_d     = 1'b0;
    end else if (!freeze) begin
      case (state_q)
        ST_SETTLE: begin
          if (err_vld && SETTLE != 0)
            set_cnt_d = (set_cnt_q == SET_LAST) ? 8'd0 : set_cnt_q + 8'd1;
        end
        ST_INTEG: begin
          if (err_vld) begin
            if (dec_cnt_q == DEC_LAST) begin
              dec_cnt_d = '0;
              if (ovf) begin
                sat_d = 1'b1;
                acc_d = sat_mode ? clamp_val : acc_l;
              end else begin
                sat_d = 1'b0;
                acc_d = sum[ACC_W-1:0];
              end
            end else begin
              dec_cnt_d = dec_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    I_term       = acc_q[SHIFT+OUT_W-1:SHIFT];
    sat_flag     = sat_q;
    integ_active = (state_q == ST_INTEG);
  end

endmodule

// File: tb/tb_i_term_accum.sv
// tb/tb_i_term_accum.sv - self-checking bench for i_term_accum (default and decimated/leaky instances)
module tb_i_term_accum;

  logic              clk;
  logic              rst;
  logic [10:0]       err_sat;
  logic              err_vld, go, moving, line_present, sat_mode, freeze;
  logic [9:0]        iterm_a, iterm_b;
  logic              sat_a, sat_b, act_a, act_b;

  int checks = 0;
  int errors = 0;

  i_term_accum dut_a (
    .clk(clk), .rst(rst), .err_sat(err_sat), .err_vld(err_vld), .go(go), .moving(moving),
    .line_present(line_present), .sat_mode(sat_mode), .freeze(freeze),
    .I_term(iterm_a), .sat_flag(sat_a), .integ_active(act_a)
  );

  i_term_accum #(.DECIM(4), .LEAK_SH(3), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .err_sat(err_sat), .err_vld(err_vld), .go(go), .moving(moving),
    .line_present(line_present), .sat_mode(sat_mode), .freeze(freeze),
    .I_term(iterm_b), .sat_flag(sat_b), .integ_active(act_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 settling, 2 integrating; counts kept as sample tallies.
  int     P_SET[2] = '{2, 0};
  int     P_DEC[2] = '{1, 4};
  int     P_LK[2]  = '{0, 3};
  longint m_acc[2];
  bit     m_lq[2];
  bit     m_sat[2];
  int     m_mode[2];
  int     m_seen[2];
  int     m_dec[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_lq[k] = 0; m_sat[k] = 0; m_mode[k] = 0; m_seen[k] = 0; m_dec[k] = 0;
    end
  endtask

  task automatic model_step();
    longint e, acc_l, s;
    bit edge_seen;
    e = longint'($signed(err_sat));
    for (int k = 0; k < 2; k++) begin
      edge_seen = line_present && !m_lq[k];
      m_lq[k] = line_present;
      if (!go || !moving || edge_seen) begin
        m_mode[k] = (!go || !moving) ? 0 : 1;
        m_acc[k] = 0; m_seen[k] = 0; m_dec[k] = 0; m_sat[k] = 0;
      end else if (!freeze) begin
        if (m_mode[k] == 0) begin
          m_mode[k] = (P_SET[k] == 0) ? 2 : 1;
        end else if (m_mode[k] == 1) begin
          if (P_SET[k] == 0) m_mode[k] = 2;
          else if (err_vld) begin
            m_seen[k]++;
            if (m_seen[k] == P_SET[k]) begin m_mode[k] = 2; m_seen[k] = 0; end
          end
        end else if (err_vld) begin
          m_dec[k]++;
          if (m_dec[k] == P_DEC[k]) begin
            m_dec[k] = 0;
            acc_l = (P_LK[k] == 0) ? m_acc[k] : m_acc[k] - (m_acc[k] >>> P_LK[k]);
            s = acc_l + e;
            if (s > 32767 || s < -32768) begin
              m_sat[k] = 1;
              m_acc[k] = sat_mode ? ((s > 0) ? 64'sd32767 : -64'sd32768) : acc_l;
            end else begin
              m_sat[k] = 0;
              m_acc[k] = s;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_models();
    chk("a_iterm", longint'(iterm_a), (m_acc[0] >>> 6) & 1023);
    chk("a_sat", longint'(sat_a), longint'(m_sat[0]));
    chk("a_active", longint'(act_a), longint'(m_mode[0] == 2));
    chk("a_acc", longint'($signed(dut_a.acc_q)), m_acc[0]);
    chk("b_iterm", longint'(iterm_b), (m_acc[1] >>> 6) & 1023);
    chk("b_sat", longint'(sat_b), longint'(m_sat[1]));
    chk("b_active", longint'(act_b), longint'(m_mode[1] == 2));
    chk("b_acc", longint'($signed(dut_b.acc_q)), m_acc[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_models();
  endtask

  task automatic samples(input int n, input int e);
    for (int i = 0; i < n; i++) begin
      err_vld = 1'b1; err_sat = 11'(e);
      tick();
    end
    err_vld = 1'b0;
  endtask

  // Reset, release with line high (edge -> settle), then pass the settle window of dut_a.
  task automatic restart();
    rst = 1'b1; err_vld = 1'b0; freeze = 1'b0; go = 1'b1; moving = 1'b1; line_present = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    samples(2, 0);
  endtask

  typedef struct {
    bit vld;
    int err;
    int exp_iterm;
    bit exp_act;
  } vec_t;

  vec_t   vt[11];
  int     exp_b[12] = '{0, 0, 0, 64, 64, 64, 64, 120, 120, 120, 120, 169};

  initial begin
    rst = 1'b1; err_sat = '0; err_vld = 1'b0; go = 1'b1; moving = 1'b1;
    line_present = 1'b1; sat_mode = 1'b0; freeze = 1'b0;
    model_reset();

    vt[0] = '{0, 0, 0, 0};
    vt[1] = '{1, 64, 0, 0};
    vt[2] = '{1, 64, 0, 1};
    for (int i = 3; i < 11; i++) vt[i] = '{1, 64, i - 2, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_iterm", longint'(iterm_a), 0);
    chk("rst_sat", longint'(sat_a), 0);
    chk("rst_active", longint'(act_a), 0);
    chk("rst_b_active", longint'(act_b), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      err_vld = vt[i].vld; err_sat = 11'(vt[i].err);
      tick();
      chk($sformatf("vec%0d_iterm", i), longint'(iterm_a), vt[i].exp_iterm);
      chk($sformatf("vec%0d_active", i), longint'(act_a), longint'(vt[i].exp_act));
      chk($sformatf("vec%0d_sat", i), longint'(sat_a), 0);
    end
    err_vld = 1'b0;
    chk("acc_512", longint'($signed(dut_a.acc_q)), 512);

    line_present = 1'b0; tick();
    line_present = 1'b1; tick();
    chk("line_clear_acc", longint'($signed(dut_a.acc_q)), 0);
    chk("line_clear_active", longint'(act_a), 0);
    samples(2, 64);
    chk("line_settle_ignored", longint'($signed(dut_a.acc_q)), 0);
    chk("line_settle_active", longint'(act_a), 1);
    go = 1'b0; tick();
    chk("go_drop_active", longint'(act_a), 0);
    chk("go_drop_acc", longint'($signed(dut_a.acc_q)), 0);
    go = 1'b1; tick();
    samples(4, 64);

    err_vld = 1'b1; err_sat = 11'(64);
    #3; rst = 1'b1; #1;
    chk("midrst_iterm", longint'(iterm_a), 0);
    chk("midrst_active", longint'(act_a), 0);
    chk("midrst_sat", longint'(sat_a), 0);
    chk("midrst_b_acc", longint'($signed(dut_b.acc_q)), 0);
    model_reset();

    sat_mode = 1'b1;
    restart();
    sat_mode = 1'b1;
    samples(32, 1023);
    chk("clamp_pre_acc", longint'($signed(dut_a.acc_q)), 32736);
    chk("clamp_pre_sat", longint'(sat_a), 0);
    samples(1, 1023);
    chk("clamp_acc", longint'($signed(dut_a.acc_q)), 32767);
    chk("clamp_iterm", longint'(iterm_a), 511);
    chk("clamp_sat", longint'(sat_a), 1);

    sat_mode = 1'b0;
    restart();
    samples(33, 1023);
    chk("hold_acc", longint'($signed(dut_a.acc_q)), 32736);
    chk("hold_sat", longint'(sat_a), 1);

    sat_mode = 1'b1;
    restart();
    samples(32, -1024);
    chk("neg_edge_sat", longint'(sat_a), 0);
    samples(1, -1024);
    chk("neg_clamp_acc", longint'($signed(dut_a.acc_q)), -32768);
    chk("neg_clamp_iterm", longint'(iterm_a), 512);
    chk("neg_clamp_sat", longint'(sat_a), 1);

    rst = 1'b1; model_reset(); sat_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      samples(1, 64);
      chk($sformatf("decim_leak_s%0d", i + 1), longint'($signed(dut_b.acc_q)), exp_b[i]);
    end

    restart();
    samples(5, 64);
    chk("pre_freeze_acc", longint'($signed(dut_a.acc_q)), 320);
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      samples(1, 64);
      chk("freeze_acc", longint'($signed(dut_a.acc_q)), 320);
      chk("freeze_dec", longint'(dut_a.dec_cnt_q), 0);
    end
    freeze = 1'b0;
    samples(1, 64);
    chk("unfreeze_acc", longint'($signed(dut_a.acc_q)), 384);

    line_present = 1'b0; tick();
    line_present = 1'b1; err_vld = 1'b1; err_sat = 11'(64); tick();
    err_vld = 1'b0;
    chk("edge_vld_acc", longint'($signed(dut_a.acc_q)), 0);
    chk("edge_vld_active", longint'(act_a), 0);
    line_present = 1'b0; tick();
    line_present = 1'b1; moving = 1'b0; tick();
    chk("stop_edge_active", longint'(act_a), 0);
    chk("stop_edge_state", longint'(dut_a.state_q), 0);
    moving = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      go           = ($urandom_range(0, 59) != 0);
      moving       = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 39) == 0) line_present = ~line_present;
      err_vld      = $urandom_range(0, 1);
      err_sat      = 11'($urandom);
      sat_mode     = $urandom_range(0, 1);
      freeze       = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
